// File: rtl/ble_pkg.sv
// Shared types and constants for the BLE command parser: command encoding,
// parser states and packet field limits.
package ble_pkg;

  typedef enum logic [1:0] {
    SWING    = 2'd0,
    PAN_L    = 2'd1,
    PAN_R    = 2'd2,
    NEW_GAME = 2'd3
  } cmd_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } parser_state_t;

  localparam logic [1:0] SWING_LEN   = 2'd3;
  localparam logic [7:0] MAX_LEN     = 8'd3;
  localparam logic [8:0] ANGLE_LIMIT = 9'd360;

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: clears on activity, counts while enabled, and pulses
// expire on the cycle it would reach LIMIT.
module inactivity_timer #(
  parameter int unsigned LIMIT = 742500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  // Clear has priority so a strobe in the expiry cycle suppresses the pulse.
  assign expire = enable && !clear && (count_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear || expire) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ble_cmd_parser.sv
// Frames UART bytes into validated swing/pan/new-game commands.
// Optional inactivity timeout compiled in with BLE_PARSER_TIMEOUT_EN.
module ble_cmd_parser
  import ble_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 742500
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       cmd_valid_out,
  output logic [1:0] cmd_type_out,
  output logic [7:0] cmd_power_out,
  output logic [8:0] cmd_angle_out,
  output logic [7:0] err_count_out,
  output logic       busy_out
);

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  parser_state_t state_q, state_d;

  logic [7:0] type_q;
  logic [1:0] len_q;
  logic [1:0] idx_q;
  logic [7:0] chk_q;
  logic [7:0] power_q;
  logic       angle_hi_q;
  logic [7:0] angle_lo_q;

  logic       timeout_hit;
  logic       accept;
  logic       reject;

`ifdef BLE_PARSER_TIMEOUT_EN
  inactivity_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk_in),
    .rst    (rst_in),
    .clear  (byte_valid_in),
    .enable (state_q != ST_IDLE),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  logic       is_swing;
  logic [8:0] angle;
  logic       pkt_ok;

  assign is_swing = (type_q == {6'd0, SWING});
  assign angle    = {angle_hi_q, angle_lo_q};
  assign pkt_ok   = (byte_in == chk_q)
                 && (type_q[7:2] == '0)
                 && (is_swing ? (len_q == SWING_LEN) : (len_q == 2'd0))
                 && (!is_swing || (angle < ANGLE_LIMIT));

  assign busy_out = (state_q != ST_IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    if (byte_valid_in) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in == SYNC_BYTE) state_d = ST_TYPE;
        end
        ST_TYPE: state_d = ST_LEN;
        ST_LEN: begin
          if (byte_in > MAX_LEN) begin
            reject  = 1'b1;
            state_d = ST_IDLE;
          end else if (byte_in == 8'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (idx_q == len_q - 2'd1) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          accept  = pkt_ok;
          reject  = !pkt_ok;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      reject  = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // Packet capture: the running XOR restarts with the TYPE byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      type_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      power_q    <= '0;
      angle_hi_q <= 1'b0;
      angle_lo_q <= '0;
    end else if (byte_valid_in) begin
      case (state_q)
        ST_TYPE: begin
          type_q <= byte_in;
          chk_q  <= byte_in;
        end
        ST_LEN: begin
          len_q <= byte_in[1:0];
          idx_q <= '0;
          chk_q <= chk_q ^ byte_in;
        end
        ST_PAYLOAD: begin
          case (idx_q)
            2'd0:    power_q    <= byte_in;
            2'd1:    angle_hi_q <= byte_in[0];
            default: angle_lo_q <= byte_in;
          endcase
          idx_q <= idx_q + 2'd1;
          chk_q <= chk_q ^ byte_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cmd_valid_out <= 1'b0;
      cmd_type_out  <= '0;
      cmd_power_out <= '0;
      cmd_angle_out <= '0;
      err_count_out <= '0;
    end else begin
      cmd_valid_out <= accept;
      if (accept) begin
        cmd_type_out  <= type_q[1:0];
        cmd_power_out <= is_swing ? power_q : '0;
        cmd_angle_out <= is_swing ? angle : '0;
      end
      if (reject && (err_count_out != '1)) begin
        err_count_out <= err_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ble_cmd_parser.sv
// Directed bench for ble_cmd_parser: packet acceptance, rejection, noise,
// timeout (when BLE_PARSER_TIMEOUT_EN is defined), reset and saturation.
module tb_ble_cmd_parser;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid_in = 1'b0;
  logic       cmd_valid_out;
  logic [1:0] cmd_type_out;
  logic [7:0] cmd_power_out;
  logic [8:0] cmd_angle_out;
  logic [7:0] err_count_out;
  logic       busy_out;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_err = 0;
  int pulses_before;

  ble_cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid_in),
    .cmd_valid_out (cmd_valid_out),
    .cmd_type_out  (cmd_type_out),
    .cmd_power_out (cmd_power_out),
    .cmd_angle_out (cmd_angle_out),
    .err_count_out (err_count_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (cmd_valid_out) pulses++;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check_cmd(input string tag, input int vld, input int typ,
                           input int pwr, input int ang);
    check({tag, "_valid"}, int'(cmd_valid_out), vld);
    check({tag, "_type"},  int'(cmd_type_out),  typ);
    check({tag, "_power"}, int'(cmd_power_out), pwr);
    check({tag, "_angle"}, int'(cmd_angle_out), ang);
    check({tag, "_err"},   int'(err_count_out), exp_err);
  endtask

  initial begin
    idle(3);
    check_cmd("in_reset", 0, 0, 0, 0);
    check("in_reset_busy", int'(busy_out), 0);
    rst_in = 1'b0;
    idle(2);
    check_cmd("after_reset", 0, 0, 0, 0);

    // Good swing: power 128, angle 0x12C = 300
    send(8'hA5); send(8'h00); send(8'h03);
    check("swing_busy", int'(busy_out), 1);
    send(8'h80); send(8'h01); send(8'h2C); send(8'hAE);
    check_cmd("swing", 1, 0, 128, 300);
    idle(1);
    check("swing_pulse_end", int'(cmd_valid_out), 0);

    // Pan left clears power/angle
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    check_cmd("pan_l", 1, 1, 0, 0);
    idle(1);

    // Bad checksum, then angle 360
    send(8'hA5); send(8'h00); send(8'h03); send(8'h80); send(8'h01); send(8'h2C); send(8'hAF);
    exp_err = 1;
    check_cmd("bad_chk", 0, 1, 0, 0);
    send(8'hA5); send(8'h00); send(8'h03); send(8'h10); send(8'h01); send(8'h68); send(8'h7A);
    exp_err = 2;
    check_cmd("angle_360", 0, 1, 0, 0);
    check("angle_360_busy", int'(busy_out), 0);

    // Noise, LEN 5, then a swing carrying A5 as payload (chk 03^A5^00^5A = FC)
    send(8'h12); send(8'h34);
    check("noise_busy", int'(busy_out), 0);
    check("noise_err", int'(err_count_out), exp_err);
    send(8'hA5); send(8'h02); send(8'h05);
    exp_err = 3;
    check("len5_err", int'(err_count_out), exp_err);
    check("len5_busy", int'(busy_out), 0);
    send(8'hA5); send(8'h00); send(8'h03); send(8'hA5); send(8'h00); send(8'h5A); send(8'hFC);
    check_cmd("embedded_sync", 1, 0, 8'hA5, 90);
    idle(1);

`ifdef BLE_PARSER_TIMEOUT_EN
    send(8'hA5); send(8'h00);
    idle(99);
    check("timeout_99_busy", int'(busy_out), 1);
    check("timeout_99_err", int'(err_count_out), exp_err);
    idle(1);
    exp_err = 4;
    check("timeout_busy", int'(busy_out), 0);
    check("timeout_err", int'(err_count_out), exp_err);
    send(8'hA5); send(8'h02); send(8'h00); send(8'h02);
    check_cmd("pan_r", 1, 2, 0, 0);
    idle(1);
`else
    send(8'hA5); send(8'h00);
    idle(200);
    check("no_timeout_busy", int'(busy_out), 1);
    check("no_timeout_err", int'(err_count_out), exp_err);
    send(8'h03); send(8'h80); send(8'h01); send(8'h2C); send(8'hAE);
    check_cmd("late_swing", 1, 0, 128, 300);
    idle(1);
`endif

    // Reset mid-packet: everything clears and the tail is treated as noise
    send(8'hA5); send(8'h00); send(8'h03);
    rst_in = 1'b1;
    idle(1);
    exp_err = 0;
    check_cmd("mid_reset", 0, 0, 0, 0);
    check("mid_reset_busy", int'(busy_out), 0);
    rst_in = 1'b0;
    pulses_before = pulses;
    send(8'h80); send(8'h01); send(8'h2C); send(8'hAE);
    idle(3);
    check("post_reset_pulses", pulses, pulses_before);
    check_cmd("post_reset", 0, 0, 0, 0);

    // Saturation with bad-checksum pan-left packets
    pulses_before = pulses;
    for (int i = 0; i < 254; i++) begin
      send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    end
    exp_err = 254;
    check("sat_254", int'(err_count_out), exp_err);
    for (int i = 0; i < 46; i++) begin
      send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
    end
    exp_err = 255;
    idle(2);
    check_cmd("sat_255", 0, 0, 0, 0);
    check("sat_no_pulse", pulses, pulses_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
